// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
//   DATA_W_DEF : default register width
//   ADDR_W_DEF : default register index width (depth = 2**ADDR_W_DEF)
//   reg_idx_t  : register index at the default width
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read path of the register file: array select, optional
// same-cycle write forwarding, and hardwired-zero masking of register 0.
// Optional feature macro: REGFILE_BYPASS_EN (enables write-to-read forwarding).
// Ports:
//   regs_i     : current register contents
//   busy_i     : current busy bits
//   rd_idx_i   : register index to read
//   wr_en_i    : accepted write this cycle (bypass build only)
//   wr_idx_i   : write destination (bypass build only)
//   wr_data_i  : write data (bypass build only)
//   rd_data_c  : combinational read data
//   rd_busy_c  : combinational busy flag of the indexed register
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic [DATA_W-1:0]    regs_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic [ADDR_W-1:0]    rd_idx_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_idx_i,
  input  logic [DATA_W-1:0]    wr_data_i,
`endif
  output logic [DATA_W-1:0]    rd_data_c,
  output logic                 rd_busy_c
);

  logic is_zero;

  // Select, forward, then mask; masking last keeps register 0 at zero
  // regardless of any forwarded write.
  always_comb begin
    is_zero   = ZERO_REG && (rd_idx_i == '0);
    rd_data_c = regs_i[rd_idx_i];
    rd_busy_c = busy_i[rd_idx_i];
`ifdef REGFILE_BYPASS_EN
    // The reader is older than any same-cycle issue, so the write clears busy.
    if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
      rd_data_c = wr_data_i;
      rd_busy_c = 1'b0;
    end
`endif
    if (is_zero) begin
      rd_data_c = '0;
      rd_busy_c = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Register file (2**ADDR_W x DATA_W) with two async read ports, one
// synchronous write port and a per-register busy scoreboard with a
// running count of busy registers, used for read-after-write stalls.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   sigRegWrite/writeReg/writeData : write-back strobe, destination, data
//   sigIssue/issueReg      : mark issueReg as awaiting a producer
//   readReg1/2             : read indices
//   readData1/2, readBusy1/2 : combinational read data and busy flags
//   pendingCount           : registered number of busy registers
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sigRegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              sigIssue,
  input  logic [ADDR_W-1:0] issueReg,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              readBusy1,
  output logic              readBusy2,
  output logic [ADDR_W:0]   pendingCount
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ok, iss_ok, cnt_inc, cnt_dec;

  // Next state: write clears busy, issue then sets it (newer producer wins).
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    wr_ok   = sigRegWrite && !(ZERO_REG && (writeReg == '0));
    iss_ok  = sigIssue    && !(ZERO_REG && (issueReg == '0));
    if (wr_ok) begin
      regs_d[writeReg] = writeData;
      busy_d[writeReg] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[issueReg] = 1'b1;
    end
    cnt_inc = iss_ok && !busy_q[issueReg];
    cnt_dec = wr_ok && busy_q[writeReg] && !(iss_ok && (issueReg == writeReg));
    count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '{default: '0};
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign pendingCount = count_q;

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .rd_idx_i  (readReg1),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (wr_ok),
    .wr_idx_i  (writeReg),
    .wr_data_i (writeData),
`endif
    .rd_data_c (readData1),
    .rd_busy_c (readBusy1)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .regs_i    (regs_q),
    .busy_i    (busy_q),
    .rd_idx_i  (readReg2),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (wr_ok),
    .wr_idx_i  (writeReg),
    .wr_data_i (writeData),
`endif
    .rd_data_c (readData2),
    .rd_busy_c (readBusy2)
  );

endmodule
